// File: rtl/pipeline_if_responder.sv
// Instruction-fetch responder: takes one fetch at a time, reads the boot ROM or the DRAM
// port, and buffers {inst, pc, fault} in a small FIFO that feeds the IF/ID boundary.
module pipeline_if_responder #(
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        req_sel,
  output logic        req_ready,
  input  logic        flush,
  output logic        rom_en,
  output logic [63:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        dram_req,
  output logic [63:0] dram_addr,
  output logic [2:0]  dram_rd_ctrl,
  input  logic        dram_ack,
  input  logic [63:0] dram_rdata,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TmoW-1:0]   TmoLast    = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [CountW-1:0] CountFull  = CountW'(FIFO_DEPTH);
  localparam logic [2:0]        DramRdCtrl = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRomWait,
    StDramWait,
    StDramDrop
  } state_e;

  state_e state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic [31:0]       fifo_inst_q  [FIFO_DEPTH];
  logic [63:0]       fifo_pc_q    [FIFO_DEPTH];
  logic              fifo_fault_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;

  logic        fifo_full, fifo_empty;
  logic        accept, push, pop;
  logic [31:0] push_inst;
  logic [63:0] push_pc;
  logic        push_fault;

  // Upper half of the DRAM word carries no instruction bits.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^dram_rdata[63:32];

  assign fifo_full  = (count_q == CountFull);
  assign fifo_empty = (count_q == '0);

  // Fetch FSM next-state, request handshake, ROM strobe and push selection.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tmo_d      = tmo_q;
    push       = 1'b0;
    push_inst  = '0;
    push_pc    = pc_q;
    push_fault = 1'b0;
    rom_en     = 1'b0;
    rom_addr   = '0;
    req_ready  = (state_q == StIdle) && !fifo_full && !flush;
    accept     = req_valid && req_ready;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pc_d = req_addr;
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned PC: fault entry straight away, memory untouched.
            push       = 1'b1;
            push_pc    = req_addr;
            push_fault = 1'b1;
          end else if (!req_sel) begin
            rom_en   = 1'b1;
            rom_addr = req_addr;
            state_d  = StRomWait;
          end else begin
            tmo_d   = '0;
            state_d = StDramWait;
          end
        end
      end
      StRomWait: begin
        state_d = StIdle;
        if (!flush) begin
          push      = 1'b1;
          push_inst = rom_data;
        end
      end
      StDramWait: begin
        tmo_d = tmo_q + TmoW'(1);
        if (dram_ack) begin
          // A completing read needs no drop phase even when flushed.
          state_d = StIdle;
          if (!flush) begin
            push      = 1'b1;
            push_inst = dram_rdata[31:0];
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StIdle;
          if (!flush) begin
            push       = 1'b1;
            push_fault = 1'b1;
          end
        end else if (flush) begin
          state_d = StDramDrop;
        end
      end
      StDramDrop: begin
        // Keep the request up until the memory finishes, then discard.
        tmo_d = tmo_q + TmoW'(1);
        if (dram_ack || (tmo_q == TmoLast)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = inst_valid && !stall && !flush;

  // FSM state, captured PC and DRAM wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tmo_q   <= tmo_d;
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      fifo_inst_q[wr_ptr_q]  <= push_inst;
      fifo_pc_q[wr_ptr_q]    <= push_pc;
      fifo_fault_q[wr_ptr_q] <= push_fault;
    end
  end

  // Head-of-FIFO outputs, zeroed when empty.
  always_comb begin
    inst_valid = !fifo_empty;
    inst       = '0;
    inst_pc    = '0;
    inst_fault = 1'b0;
    if (inst_valid) begin
      inst       = fifo_inst_q[rd_ptr_q];
      inst_pc    = fifo_pc_q[rd_ptr_q];
      inst_fault = fifo_fault_q[rd_ptr_q];
    end
  end

  // DRAM port; reset drops the request within the reset cycle.
  always_comb begin
    dram_req     = ((state_q == StDramWait) || (state_q == StDramDrop)) && !reset;
    dram_addr    = '0;
    dram_rd_ctrl = 3'b000;
    if (dram_req) begin
      dram_addr    = pc_q;
      dram_rd_ctrl = DramRdCtrl;
    end
  end

endmodule
